// File: rtl/mmio_pkg.sv
// Shared constants for the MIPS I/O region: region nibble and register offsets.
package mmio_pkg;

  localparam logic [3:0] IO_REGION   = 4'b1000;

  localparam logic [7:0] OFF_TX_STAT = 8'h00;
  localparam logic [7:0] OFF_RX_STAT = 8'h04;
  localparam logic [7:0] OFF_RX_DATA = 8'h08;
  localparam logic [7:0] OFF_TX_DATA = 8'h0C;
  localparam logic [7:0] OFF_CYC     = 8'h10;
  localparam logic [7:0] OFF_INSTR   = 8'h14;
  localparam logic [7:0] OFF_CNT_RST = 8'h18;

  function automatic logic is_io_reg(input logic [7:0] off);
    return (off == OFF_TX_STAT) || (off == OFF_RX_STAT) || (off == OFF_RX_DATA) ||
           (off == OFF_TX_DATA) || (off == OFF_CYC)     || (off == OFF_INSTR)   ||
           (off == OFF_CNT_RST);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset; push is ignored when full, pop when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio_unit.sv
// Memory-mapped UART and counter registers for the 0x8xxx_xxxx region of the MIPS pipeline.
module uart_mmio_unit
  import mmio_pkg::*;
#(
  parameter int RX_DEPTH = 4,
  parameter int CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] addr_e,
  input  logic        load_e,
  input  logic        store_e,
  input  logic [31:0] wdata_e,
  input  logic        retire,
  output logic [31:0] rdata_m,
  output logic        hit_m,
  output logic [7:0]  uart_din,
  output logic        uart_din_valid,
  input  logic        uart_din_ready,
  input  logic [7:0]  uart_dout,
  input  logic        uart_dout_valid,
  output logic        uart_dout_ready
);

  localparam int CW = $clog2(RX_DEPTH) + 1;

  logic             is_io;
  logic [7:0]       off;
  logic             is_load;
  logic             is_store;

  logic             rx_full;
  logic             rx_empty;
  logic [CW-1:0]    rx_count;
  logic [7:0]       rx_head;
  logic             rx_push;
  logic             rx_pop;
  logic [2:0]       rx_count_sat;

  logic [7:0]       tx_byte;
  logic             tx_full;
  logic             tx_ovf;
  logic             tx_handoff;
  logic             tx_write;
  logic             tx_accept;

  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] instr_cnt;
  logic             cnt_clear;

  logic [31:0]      rd_val;
  logic             rd_hit;
  logic             unused_bits;

  assign unused_bits = ^{addr_e[27:8], wdata_e[31:8]};

  // A simultaneous load and store is treated as a store.
  assign is_io    = (addr_e[31:28] == IO_REGION);
  assign off      = addr_e[7:0];
  assign is_store = store_e;
  assign is_load  = load_e && !store_e;

  assign uart_dout_ready = !rx_full;
  assign rx_push         = uart_dout_valid && !rx_full;
  assign rx_pop          = is_load && is_io && (off == OFF_RX_DATA) && !stall && !rx_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .din   (uart_dout),
    .pop   (rx_pop),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  always_comb begin
    rx_count_sat = 3'd7;
    if (32'(rx_count) < 32'd7) begin
      rx_count_sat = 3'(rx_count);
    end
  end

  assign uart_din_valid = tx_full;
  assign uart_din       = tx_byte;
  assign tx_handoff     = tx_full && uart_din_ready;
  assign tx_write       = is_store && is_io && (off == OFF_TX_DATA) && !stall;
  assign tx_accept      = !tx_full || tx_handoff;
  assign cnt_clear      = is_store && is_io && (off == OFF_CNT_RST) && !stall;

  // Write-only registers (TX data, counter reset) still count as hits but read as zero.
  always_comb begin
    rd_val = '0;
    rd_hit = 1'b0;
    if (is_load && is_io && is_io_reg(off)) begin
      rd_hit = 1'b1;
      case (off)
        OFF_TX_STAT: rd_val = {30'd0, tx_ovf, !tx_full};
        OFF_RX_STAT: rd_val = {28'd0, rx_count_sat, !rx_empty};
        OFF_RX_DATA: rd_val = rx_empty ? 32'd0 : {24'd0, rx_head};
        OFF_CYC:     rd_val = 32'(cyc_cnt);
        OFF_INSTR:   rd_val = 32'(instr_cnt);
        default:     rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_m <= '0;
      hit_m   <= 1'b0;
    end else if (!stall) begin
      rdata_m <= rd_val;
      hit_m   <= rd_hit;
    end
  end

  // A store that finds the holding register busy is dropped and recorded as overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_byte <= '0;
      tx_full <= 1'b0;
      tx_ovf  <= 1'b0;
    end else begin
      if (tx_write && tx_accept) begin
        tx_byte <= wdata_e[7:0];
        tx_full <= 1'b1;
      end else if (tx_handoff) begin
        tx_full <= 1'b0;
      end
      if (cnt_clear) begin
        tx_ovf <= 1'b0;
      end else if (tx_write && !tx_accept) begin
        tx_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt   <= '0;
      instr_cnt <= '0;
    end else if (cnt_clear) begin
      cyc_cnt   <= '0;
      instr_cnt <= '0;
    end else begin
      cyc_cnt   <= cyc_cnt + 1'b1;
      instr_cnt <= instr_cnt + CNT_W'(retire);
    end
  end

endmodule

// File: tb/tb_uart_mmio_unit.sv
// Randomised scoreboard bench for uart_mmio_unit against a queue-based reference model.
module tb_uart_mmio_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] addr_e = '0;
  logic        load_e = 1'b0;
  logic        store_e = 1'b0;
  logic [31:0] wdata_e = '0;
  logic        retire = 1'b0;
  logic [31:0] rdata_m;
  logic        hit_m;
  logic [7:0]  uart_din;
  logic        uart_din_valid;
  logic        uart_din_ready = 1'b1;
  logic [7:0]  uart_dout = '0;
  logic        uart_dout_valid = 1'b0;
  logic        uart_dout_ready;

  always #5 clk = ~clk;

  uart_mmio_unit #(.RX_DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .addr_e          (addr_e),
    .load_e          (load_e),
    .store_e         (store_e),
    .wdata_e         (wdata_e),
    .retire          (retire),
    .rdata_m         (rdata_m),
    .hit_m           (hit_m),
    .uart_din        (uart_din),
    .uart_din_valid  (uart_din_valid),
    .uart_din_ready  (uart_din_ready),
    .uart_dout       (uart_dout),
    .uart_dout_valid (uart_dout_valid),
    .uart_dout_ready (uart_dout_ready)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        hit;
    logic        din_valid;
    logic [7:0]  din;
    logic        dout_ready;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: the RX FIFO is just a queue of bytes.
  logic [7:0]  rx_q[$];
  bit          m_tx_full;
  logic [7:0]  m_tx_byte;
  bit          m_ovf;
  logic [31:0] m_cyc;
  logic [31:0] m_instr;
  logic [31:0] m_rdata;
  bit          m_hit;
  bit          force_cyc = 1'b0;

  task automatic modelReset();
    rx_q.delete();
    m_tx_full = 0; m_tx_byte = '0; m_ovf = 0;
    m_cyc = '0; m_instr = '0; m_rdata = '0; m_hit = 0;
  endtask

  task automatic modelStep(input bit s, input logic [31:0] a, input bit ld, input bit st,
                           input logic [7:0] wd, input bit ret, input bit dr,
                           input logic [7:0] rxb, input bit rxv);
    bit          io;
    logic [7:0]  o;
    bit          is_ld;
    logic [31:0] rv;
    bit          h;
    bit          room;
    bit          handoff;
    bit          clear;
    int          sat;
    io    = (a[31:28] == 4'h8);
    o     = a[7:0];
    is_ld = ld && !st;
    rv    = '0;
    h     = 0;
    sat   = (rx_q.size() > 7) ? 7 : rx_q.size();
    if (is_ld && io) begin
      h = 1;
      case (o)
        8'h00:   rv = {30'd0, m_ovf, !m_tx_full};
        8'h04:   rv = {28'd0, 3'(sat), rx_q.size() != 0};
        8'h08:   rv = (rx_q.size() != 0) ? {24'd0, rx_q[0]} : 32'd0;
        8'h0C:   rv = '0;
        8'h10:   rv = m_cyc;
        8'h14:   rv = m_instr;
        8'h18:   rv = '0;
        default: h = 0;
      endcase
    end
    room = rx_q.size() < DEPTH;
    if (!s && is_ld && io && o == 8'h08 && rx_q.size() != 0) void'(rx_q.pop_front());
    if (rxv && room) rx_q.push_back(rxb);
    handoff = m_tx_full && dr;
    if (!s && st && io && o == 8'h0C) begin
      if (!m_tx_full || handoff) begin
        m_tx_byte = wd;
        m_tx_full = 1;
      end else begin
        m_ovf = 1;
      end
    end else if (handoff) begin
      m_tx_full = 0;
    end
    clear = !s && st && io && o == 8'h18;
    if (clear) begin
      m_cyc = '0; m_instr = '0; m_ovf = 0;
    end else begin
      m_cyc   = m_cyc + 1;
      m_instr = m_instr + 32'(ret);
    end
    if (!s) begin
      m_rdata = rv;
      m_hit   = h;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit s, input logic [31:0] a, input bit ld,
                               input bit st, input logic [7:0] wd, input bit ret, input bit dr,
                               input logic [7:0] rxb, input bit rxv);
    exp_t e;
    @(negedge clk);
    if (force_cyc) begin
      force dut.cyc_cnt = 32'hFFFF_FFFF;
      release dut.cyc_cnt;
      m_cyc = 32'hFFFF_FFFF;
      force_cyc = 1'b0;
    end
    rst = r; stall = s; addr_e = a; load_e = ld; store_e = st;
    wdata_e = {$urandom_range(0, 255), 16'h0, wd};
    retire = ret; uart_din_ready = dr; uart_dout = rxb; uart_dout_valid = rxv;
    if (r) modelReset();
    else modelStep(s, a, ld, st, wd, ret, dr, rxb, rxv);
    e.rdata = m_rdata; e.hit = m_hit; e.din_valid = m_tx_full;
    e.din = m_tx_byte; e.dout_ready = rx_q.size() < DEPTH;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    checks += 5;
    if (rdata_m !== e.rdata) begin
      errors++; $display("[TB] FAIL rdata_m: got %h expected %h at %0t", rdata_m, e.rdata, $time);
    end
    if (hit_m !== e.hit) begin
      errors++; $display("[TB] FAIL hit_m: got %b expected %b at %0t", hit_m, e.hit, $time);
    end
    if (uart_din_valid !== e.din_valid) begin
      errors++; $display("[TB] FAIL uart_din_valid: got %b expected %b at %0t", uart_din_valid, e.din_valid, $time);
    end
    if (uart_din !== e.din) begin
      errors++; $display("[TB] FAIL uart_din: got %h expected %h at %0t", uart_din, e.din, $time);
    end
    if (uart_dout_ready !== e.dout_ready) begin
      errors++; $display("[TB] FAIL uart_dout_ready: got %b expected %b at %0t", uart_dout_ready, e.dout_ready, $time);
    end
  endtask

  // Monitor: each cycle's expectation is popped just after the edge it describes.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 32'h0, 0, 0, 8'h0, 0, 1, 8'h0, 0);
  endtask
  task automatic ioLoad(input logic [7:0] o, input bit s = 0, input bit dr = 1);
    applyStimulus(0, s, {24'h800000, o}, 1, 0, 8'h0, 0, dr, 8'h0, 0);
  endtask
  task automatic ioStore(input logic [7:0] o, input logic [7:0] d, input bit ret = 0, input bit dr = 1);
    applyStimulus(0, 0, {24'h800000, o}, 0, 1, d, ret, dr, 8'h0, 0);
  endtask
  task automatic rxByte(input logic [7:0] b, input bit dr = 1);
    applyStimulus(0, 0, 32'h0, 0, 0, 8'h0, 0, dr, b, 1);
  endtask

  initial begin
    logic [31:0] rnd;
    logic [7:0]  offs [10];
    logic [3:0]  region;
    int          kind;
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h09, 8'h40};
    modelReset();
    applyStimulus(1, 0, 32'h0, 0, 0, 8'h0, 0, 1, 8'h0, 0);
    applyStimulus(1, 0, 32'h0, 0, 0, 8'h0, 0, 1, 8'h0, 0);

    $display("[TB] RX order");
    rxByte(8'h41); rxByte(8'h42);
    ioLoad(8'h08); ioLoad(8'h08); ioLoad(8'h08); idle(1);

    $display("[TB] RX full");
    for (int i = 0; i < 4; i++) rxByte(8'h10 + 8'(i));
    rxByte(8'h55); rxByte(8'h55);
    ioLoad(8'h08); idle(1);
    for (int i = 0; i < 5; i++) ioLoad(8'h08);

    $display("[TB] TX overflow");
    ioStore(8'h0C, 8'h61, 0, 0); ioStore(8'h0C, 8'h62, 0, 0);
    ioLoad(8'h00, 0, 0); idle(0);
    applyStimulus(0, 0, 32'h0, 0, 0, 8'h0, 0, 1, 8'h0, 0);
    ioLoad(8'h00, 0, 0);

    $display("[TB] Stall");
    rxByte(8'h77); rxByte(8'h78); ioLoad(8'h04);
    ioLoad(8'h08, 1); ioLoad(8'h08, 1); ioLoad(8'h08, 0); ioLoad(8'h08, 0);

    $display("[TB] Counters");
    applyStimulus(1, 0, 32'h0, 0, 0, 8'h0, 0, 1, 8'h0, 0);
    for (int i = 0; i < 10; i++)
      applyStimulus(0, 0, 32'h0, 0, 0, 8'h0, (i % 3 == 1), 1, 8'h0, 0);
    ioLoad(8'h14); ioLoad(8'h00);
    ioStore(8'h18, 8'h0, 1); ioLoad(8'h14); ioLoad(8'h10);
    force_cyc = 1'b1;
    ioLoad(8'h10); ioLoad(8'h10);

    $display("[TB] Reset mid-operation");
    ioStore(8'h0C, 8'h99, 0, 0); rxByte(8'hA1, 0); rxByte(8'hA2, 0);
    applyStimulus(1, 0, 32'h0, 0, 0, 8'h0, 0, 0, 8'h0, 0);
    ioLoad(8'h04, 0, 0); ioLoad(8'h00, 0, 0);

    $display("[TB] Random traffic");
    for (int i = 0; i < 3000; i++) begin
      rnd    = $urandom();
      region = ($urandom_range(0, 3) != 0) ? 4'h8 : 4'($urandom_range(0, 15));
      kind   = $urandom_range(0, 9);
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 4) == 0,
                    {region, rnd[27:8], offs[$urandom_range(0, 9)]},
                    (kind < 4) || (kind == 6), (kind >= 4) && (kind <= 6),
                    8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 2) == 0, 8'($urandom_range(0, 255)),
                    $urandom_range(0, 2) == 0);
    end
    idle(2);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
